// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and writeback selects for multi_cycle_ctrl.
// The TRAP state only exists when ILLEGAL_TRAP_EN is defined.
package multi_cycle_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EX  = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4
`ifdef ILLEGAL_TRAP_EN
      , ST_TRAP = 3'd5
`endif
   } state_e;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bus bundle between the multi-cycle controller (master) and the datapath/memories (slave).
interface multi_cycle_ctrl_if;
   // Handshakes: a request (imem_req/dmem_req) stays high until the matching ready is
   // seen in the same cycle; a ready arriving in the first request cycle completes it.
   logic        imem_req;
   logic        imem_ready;
   logic        ir_we;
   logic [31:0] pc;
   logic [6:0]  opcode;
   logic [31:0] imm32;
   logic [31:0] rs1_val;
   logic        br_taken;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic        retire;
   logic        illegal;

   modport master (
      output imem_req, ir_we, pc, dmem_req, dmem_we, reg_we, wb_sel, state, retire, illegal,
      input  imem_ready, opcode, imm32, rs1_val, br_taken, dmem_ready
   );

   modport slave (
      input  imem_req, ir_we, pc, dmem_req, dmem_we, reg_we, wb_sel, state, retire, illegal,
      output imem_ready, opcode, imm32, rs1_val, br_taken, dmem_ready
   );
endinterface

// File: rtl/multi_cycle_ctrl_pc_next_unit.sv
// Next-PC computation for the retiring instruction; all sums wrap modulo 2^32.
module pc_next_unit
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [6:0]  opcode,
   input  logic [31:0] imm32,
   input  logic [31:0] rs1_val,
   input  logic        br_taken,
   output logic [31:0] pc_next
);

   logic [31:0] jalr_tgt;

   always_comb begin
      jalr_tgt = rs1_val + imm32;
      pc_next  = pc + 32'd4;
      case (opcode)
         OP_JAL:    pc_next = pc + imm32;
         OP_JALR:   pc_next = {jalr_tgt[31:1], 1'b0};
         OP_BRANCH: if (br_taken) pc_next = pc + imm32;
         default:   ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB instruction controller with PC register.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they execute as NOP.
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   multi_cycle_ctrl_if.master   bus
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, pc_next;

   logic        is_load, is_store, to_wb, use_mem;
   logic        imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, retire_c;
   logic [1:0]  wb_sel_c;

   assign is_load  = (bus.opcode == OP_LOAD);
   assign is_store = (bus.opcode == OP_STORE);
   assign use_mem  = is_load | is_store;
   assign to_wb    = bus.opcode inside {OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

`ifdef ILLEGAL_TRAP_EN
   logic known_op;
   assign known_op = use_mem | to_wb | (bus.opcode == OP_BRANCH);
`endif

   pc_next_unit u_pc_next (
      .pc       (pc_q),
      .opcode   (bus.opcode),
      .imm32    (bus.imm32),
      .rs1_val  (bus.rs1_val),
      .br_taken (bus.br_taken),
      .pc_next  (pc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IF;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IF:  if (bus.imem_ready) state_d = ST_ID;
         ST_ID: begin
            state_d = ST_EX;
`ifdef ILLEGAL_TRAP_EN
            if (!known_op) state_d = ST_TRAP;
`endif
         end
         // Anything that is neither a memory op nor a writeback op retires here.
         ST_EX: begin
            if (use_mem)    state_d = ST_MEM;
            else if (to_wb) state_d = ST_WB;
            else            state_d = ST_IF;
         end
         ST_MEM: if (bus.dmem_ready) state_d = is_load ? ST_WB : ST_IF;
         ST_WB:  state_d = ST_IF;
`ifdef ILLEGAL_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;
`endif
         default: state_d = ST_IF;
      endcase
   end

   always_comb begin
      imem_req_c = 1'b0;
      ir_we_c    = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      reg_we_c   = 1'b0;
      retire_c   = 1'b0;
      wb_sel_c   = WB_ALU;
      case (state_q)
         ST_IF: begin
            imem_req_c = 1'b1;
            ir_we_c    = bus.imem_ready;
         end
         ST_EX:  retire_c = !use_mem && !to_wb;
         ST_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = is_store;
            retire_c   = is_store && bus.dmem_ready;
         end
         ST_WB: begin
            reg_we_c = 1'b1;
            retire_c = 1'b1;
            if (is_load)                                          wb_sel_c = WB_MEM;
            else if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) wb_sel_c = WB_PC4;
            else if (bus.opcode == OP_LUI)                        wb_sel_c = WB_IMM;
         end
         default: ;
      endcase
   end

   always_comb begin
      pc_d = retire_c ? pc_next : pc_q;
   end

   // Reset forces every output quiet in the same cycle, ahead of any ready.
   assign bus.imem_req = imem_req_c & ~rst;
   assign bus.ir_we    = ir_we_c & ~rst;
   assign bus.dmem_req = dmem_req_c & ~rst;
   assign bus.dmem_we  = dmem_we_c & ~rst;
   assign bus.reg_we   = reg_we_c & ~rst;
   assign bus.retire   = retire_c & ~rst;
   assign bus.wb_sel   = rst ? WB_ALU : wb_sel_c;
   assign bus.pc       = rst ? RESET_PC : pc_q;
   assign bus.state    = state_q;
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal  = (state_q == ST_TRAP) & ~rst;
`else
   assign bus.illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction behavioural model expanded into
// a per-cycle stimulus/expectation queue, directed cases plus randomized instruction streams.
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst;

   multi_cycle_ctrl_if bus_if ();

   multi_cycle_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        imem_ready;
      logic        dmem_ready;
      logic [6:0]  opcode;
      logic [31:0] imm32;
      logic [31:0] rs1_val;
      logic        br_taken;
      logic        chk_state;
   } cyc_t;

   // exp layout: imem_req, ir_we, dmem_req, dmem_we, reg_we, retire, illegal, wb_sel[2], state[3], pc[32]
   cyc_t        stim_q[$];
   logic [43:0] exp_q[$];

   logic [31:0] m_pc;
   logic        m_trapped;

   int n_vec  = 0;
   int n_fail = 0;
   int run_cyc, ret_cyc, ret_cnt, regwe_cnt, dreq_cnt, ireq_cnt;
   logic [1:0] wbsel_seen;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic cyc_t mk(input logic r, input logic ir, input logic dr, input logic [6:0] op,
                               input logic [31:0] imm, input logic [31:0] rs1, input logic br,
                               input logic chk);
      cyc_t c;
      c.rst = r; c.imem_ready = ir; c.dmem_ready = dr; c.opcode = op;
      c.imm32 = imm; c.rs1_val = rs1; c.br_taken = br; c.chk_state = chk;
      return c;
   endfunction

   function automatic logic [43:0] pack_exp(input logic ireq, input logic irwe, input logic dreq,
                                            input logic dwe, input logic rwe, input logic ret,
                                            input logic ill, input logic [1:0] wb,
                                            input logic [2:0] st, input logic [31:0] pc);
      return {ireq, irwe, dreq, dwe, rwe, ret, ill, wb, st, pc};
   endfunction

   task automatic push(input cyc_t c, input logic [43:0] e);
      stim_q.push_back(c);
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      run_cyc = 0; ret_cyc = 0; ret_cnt = 0; regwe_cnt = 0; dreq_cnt = 0; ireq_cnt = 0;
      wbsel_seen = 2'd0;
   endtask

   task automatic gen_reset();
      push(mk(1'b1, rbit(), rbit(), 7'($urandom), $urandom, $urandom, rbit(), 1'b0),
           pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, RESET_PC));
      m_pc      = RESET_PC;
      m_trapped = 1'b0;
   endtask

   // Expands one instruction into its cycles; limit>0 truncates it (caller follows with reset).
   task automatic gen_instr(input logic [6:0] op, input logic [31:0] imm, input logic [31:0] rs1,
                            input logic br, input int wi, input int wd, input int limit);
      int n;
      logic ld, st, to_wb, ret_ex;
      logic [1:0] wsel;
      logic [31:0] npc;
      n     = 0;
      ld    = (op == OP_LOAD);
      st    = (op == OP_STORE);
      to_wb = op inside {OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
      wsel  = ld ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : (op == OP_LUI) ? 2'd3 : 2'd0;
      case (op)
         OP_JAL:    npc = m_pc + imm;
         OP_JALR:   npc = (rs1 + imm) & 32'hFFFF_FFFE;
         OP_BRANCH: npc = br ? m_pc + imm : m_pc + 32'd4;
         default:   npc = m_pc + 32'd4;
      endcase
      for (int i = 0; i <= wi; i++) begin
         push(mk(1'b0, (i == wi), rbit(), 7'($urandom), $urandom, $urandom, rbit(), 1'b1),
              pack_exp(1'b1, (i == wi), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ST_IF, m_pc));
         n++; if (n == limit) return;
      end
      push(mk(1'b0, rbit(), rbit(), op, imm, rs1, br, 1'b1),
           pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ST_ID, m_pc));
      n++; if (n == limit) return;
`ifdef ILLEGAL_TRAP_EN
      if (!(ld || st || to_wb || op == OP_BRANCH)) begin
         for (int i = 0; i < 3; i++) begin
            push(mk(1'b0, rbit(), rbit(), op, imm, rs1, br, 1'b1),
                 pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, ST_TRAP, m_pc));
            n++; if (n == limit) return;
         end
         m_trapped = 1'b1;
         return;
      end
`endif
      ret_ex = !(ld || st) && !to_wb;
      push(mk(1'b0, rbit(), rbit(), op, imm, rs1, br, 1'b1),
           pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ret_ex, 1'b0, 2'd0, ST_EX, m_pc));
      n++; if (n == limit) return;
      if (ret_ex) begin
         m_pc = npc;
         return;
      end
      if (ld || st) begin
         for (int i = 0; i <= wd; i++) begin
            push(mk(1'b0, rbit(), (i == wd), op, imm, rs1, br, 1'b1),
                 pack_exp(1'b0, 1'b0, 1'b1, st, 1'b0, st && (i == wd), 1'b0, 2'd0, ST_MEM, m_pc));
            n++; if (n == limit) return;
         end
         if (st) begin
            m_pc = npc;
            return;
         end
      end
      push(mk(1'b0, rbit(), rbit(), op, imm, rs1, br, 1'b1),
           pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, wsel, ST_WB, m_pc));
      m_pc = npc;
   endtask

   // Single compare process: drives one queued cycle, checks all outputs mid-cycle.
   task automatic run_queue();
      cyc_t c;
      logic [43:0] e;
      while (stim_q.size() != 0) begin
         c = stim_q.pop_front();
         e = exp_q.pop_front();
         rst               = c.rst;
         bus_if.imem_ready = c.imem_ready;
         bus_if.dmem_ready = c.dmem_ready;
         bus_if.opcode     = c.opcode;
         bus_if.imm32      = c.imm32;
         bus_if.rs1_val    = c.rs1_val;
         bus_if.br_taken   = c.br_taken;
         @(negedge clk);
         check("imem_req", 32'(bus_if.imem_req), 32'(e[43]));
         check("ir_we",    32'(bus_if.ir_we),    32'(e[42]));
         check("dmem_req", 32'(bus_if.dmem_req), 32'(e[41]));
         check("dmem_we",  32'(bus_if.dmem_we),  32'(e[40]));
         check("reg_we",   32'(bus_if.reg_we),   32'(e[39]));
         check("retire",   32'(bus_if.retire),   32'(e[38]));
         check("illegal",  32'(bus_if.illegal),  32'(e[37]));
         check("wb_sel",   32'(bus_if.wb_sel),   32'(e[36:35]));
         check("pc",       bus_if.pc,            e[31:0]);
         if (c.chk_state) check("state", 32'(bus_if.state), 32'(e[34:32]));
         if (!c.rst) begin
            run_cyc++;
            if (bus_if.retire) begin ret_cnt++; ret_cyc = run_cyc; end
            if (bus_if.reg_we) begin regwe_cnt++; wbsel_seen = bus_if.wb_sel; end
            if (bus_if.dmem_req) dreq_cnt++;
            if (bus_if.imem_req) ireq_cnt++;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops[9];
      logic [6:0] op;
      int         limit;
      ops = '{OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};
      rst = 1'b1;
      bus_if.imem_ready = 1'b0; bus_if.dmem_ready = 1'b0; bus_if.opcode = 7'h0;
      bus_if.imm32 = 32'h0; bus_if.rs1_val = 32'h0; bus_if.br_taken = 1'b0;
      m_pc = RESET_PC; m_trapped = 1'b0;
      clear_stats();
      @(posedge clk);
      #1;
      gen_reset(); gen_reset();
      run_queue();

      // ADD from reset, zero wait
      clear_stats();
      gen_instr(OP_REG, $urandom, $urandom, rbit(), 0, 0, 0);
      run_queue();
      check("add_retire_cycle", ret_cyc, 4);
      check("add_reg_we_count", regwe_cnt, 1);
      check("add_pc", bus_if.pc, 32'h4);
      check("model_pc_add", m_pc, 32'h4);

      // LW with three data wait cycles
      clear_stats();
      gen_instr(OP_LOAD, $urandom, $urandom, rbit(), 0, 3, 0);
      run_queue();
      check("lw_dmem_req_cycles", dreq_cnt, 4);
      check("lw_wb_sel", 32'(wbsel_seen), 32'h1);
      check("lw_retire_cycle", ret_cyc, 8);

      // two fillers bring pc to 0x10, then a taken backward BEQ
      gen_instr(OP_IMM, $urandom, $urandom, rbit(), 1, 0, 0);
      gen_instr(OP_REG, $urandom, $urandom, rbit(), 0, 0, 0);
      run_queue();
      check("pre_beq_pc", bus_if.pc, 32'h10);
      clear_stats();
      gen_instr(OP_BRANCH, 32'hFFFF_FFF8, $urandom, 1'b1, 0, 0, 0);
      run_queue();
      check("beq_retire_cycle", ret_cyc, 3);
      check("beq_reg_we_count", regwe_cnt, 0);
      check("beq_pc", bus_if.pc, 32'h8);

      // JALR clears bit 0; JAL wraps past 2^32
      gen_instr(OP_JALR, 32'h4, 32'h1001, rbit(), 0, 0, 0);
      run_queue();
      check("jalr_pc", bus_if.pc, 32'h1004);
      gen_instr(OP_JALR, 32'h0, 32'hFFFF_FFFC, rbit(), 0, 0, 0);
      run_queue();
      check("jalr_to_top_pc", bus_if.pc, 32'hFFFF_FFFC);
      gen_instr(OP_JAL, 32'h8, $urandom, rbit(), 0, 0, 0);
      run_queue();
      check("jal_wrap_pc", bus_if.pc, 32'h4);
      check("model_pc_jal", m_pc, 32'h4);

      // SW abandoned by reset during its data wait
      clear_stats();
      gen_instr(OP_STORE, $urandom, $urandom, rbit(), 0, 3, 5);
      gen_reset();
      run_queue();
      check("sw_abort_retire_count", ret_cnt, 0);
      check("sw_abort_dmem_req_cycles", dreq_cnt, 2);
      check("sw_abort_pc", bus_if.pc, RESET_PC);
      gen_instr(OP_REG, $urandom, $urandom, rbit(), 2, 0, 0);
      run_queue();

      // unknown opcode 0x7F
      clear_stats();
      gen_instr(7'h7F, $urandom, $urandom, rbit(), 0, 0, 0);
      run_queue();
`ifdef ILLEGAL_TRAP_EN
      check("trap_illegal", 32'(bus_if.illegal), 32'h1);
      check("trap_state", 32'(bus_if.state), 32'(ST_TRAP));
      check("trap_imem_req_cycles", ireq_cnt, 1);
      gen_reset();
      run_queue();
`else
      check("nop_retire_cycle", ret_cyc, 3);
      check("nop_pc", bus_if.pc, 32'h8);
`endif

      // randomized instruction stream with random waits and occasional resets
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 10))
            9:       op = 7'h7F;
            10:      op = 7'($urandom);
            default: op = ops[$urandom_range(0, 8)];
         endcase
         limit = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 6)) : 0;
         gen_instr(op, $urandom, $urandom, rbit(), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), limit);
         if (limit != 0 || m_trapped) gen_reset();
         run_queue();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
- REQ-002: Clock is clk and reset is rst; one clock; reset is synchronous and active-high.
- REQ-003: clk  in  1  system clock, all state updates on rising edge.
- REQ-004: rst  in  1  synchronous active-high reset.
- REQ-005: imem_req  out  1  instruction fetch request.
- REQ-006: imem_ready  in  1  instruction word valid this cycle.
- REQ-007: ir_we  out  1  one-cycle pulse that latches the fetched instruction into IR.
- REQ-008: pc  out  32  current instruction address.
- REQ-009: opcode  in  7  decoded opcode of IR, using the shared opcode constants.
- REQ-010: imm32  in  32  decoded immediate of IR.
- REQ-011: rs1_val  in  32  register-file rs1 read value.
- REQ-012: br_taken  in  1  branch comparator result, valid in EX.
- REQ-013: dmem_req  out  1  data memory request; dmem_we  out  1  store when high.
- REQ-014: dmem_ready  in  1  data access complete this cycle.
- REQ-015: reg_we  out  1  register-file write enable.
- REQ-016: wb_sel  out  2  writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
- REQ-017: state  out  3  current FSM state encoding, for debug.
- REQ-018: retire  out  1  one-cycle pulse per completed instruction.
- REQ-019: illegal  out  1  sticky illegal-opcode flag (macro-dependent).

Function
- REQ-020: The FSM SHALL have states IF, ID, EX, MEM, WB, and TRAP; TRAP exists only with the macro.
- REQ-021: IF SHALL hold imem_req=1 until imem_ready, then pulse ir_we in that cycle and go to ID; an imem_ready that arrives in the same cycle as the request SHALL be accepted.
- REQ-022: ID SHALL last exactly one cycle and go to EX.
- REQ-023: EX SHALL route as follows:
  - L or S: go to MEM.
  - B: retire, update PC, go to IF.
  - R, I, LUI, AUIPC, JAL or JALR: go to WB.
- REQ-024: MEM SHALL hold dmem_req=1 (dmem_we=1 for S) until dmem_ready.
  - L: on dmem_ready, go to WB.
  - S: on dmem_ready, retire, PC+4, go to IF.
- REQ-025: WB SHALL assert reg_we for one cycle, retire, update PC and go to IF; wb_sel is MEM for L, PC+4 for JAL/JALR, IMM for LUI, and ALU otherwise.
- REQ-026: PC update SHALL occur only on the retiring edge:
  - pc+imm32 for JAL, and for B when br_taken=1.
  - (rs1_val+imm32) with bit 0 cleared for JALR.
  - pc+4 otherwise.
  - All sums are modulo 2^32, so wrap-around is silent.
- REQ-027: Minimum latency in cycles (zero memory wait) SHALL be: B=3, R/I/LUI/AUIPC/JAL/JALR/S=4, L=5; each wait cycle adds one.
- REQ-028: Outputs not named active in a state SHALL be 0 in that state.

Reset
- REQ-029: While rst=1, all single-bit outputs SHALL be 0, wb_sel=0, pc=RESET_PC, and the next state SHALL be IF.
- REQ-030: Reset in any state, including a MEM or IF wait, SHALL abandon the access; the next cycle has state=IF, dmem_req=0, pc=RESET_PC, illegal=0.
- REQ-031: reset SHALL take priority over imem_ready and dmem_ready arriving in the same cycle.

Configuration
- REQ-032: Macro ILLEGAL_TRAP_EN controls unknown-opcode handling.
  - Defined: an unknown opcode in ID SHALL go to TRAP, set illegal=1, and stay there with all requests 0 until reset.
  - Undefined: an unknown opcode SHALL be executed as NOP (ID to EX to IF, retire, PC+4), illegal SHALL be tied 0, and TRAP SHALL not exist.

Structure
- REQ-033: Opcode constants and state encodings SHALL live in the shared define/package include.
- REQ-034: The PC next-value logic SHALL be one sub-module, pc_next_unit; everything else stays flat.

Verification
- REQ-035: ADD (opcode R) with imem_ready and dmem_ready always high -> retire exactly 4 cycles after reset release, reg_we=1 in WB, pc=0x4.
- REQ-036: LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, wb_sel=1, retire at cycle 8.
- REQ-037: BEQ with imm32=0xFFFFFFF8, br_taken=1, at pc=0x10 -> pc=0x08 after 3 cycles, reg_we never 1.
- REQ-038: JALR with rs1_val=0x1001 and imm32=0x4 -> pc=0x1004; JAL with imm32=0x8 at pc=0xFFFFFFFC -> pc=0x4 (wrap-around).
- REQ-039: rst asserted during a MEM wait of an SW -> next cycle state=IF, dmem_req=0, pc=RESET_PC, no retire.
- REQ-040: Opcode 7'h7F with ILLEGAL_TRAP_EN defined -> TRAP, illegal=1, imem_req stays 0; without the macro -> retire after 3 cycles, pc+4.
